// File: rtl/scarv_mem_pkg.sv
// rtl/scarv_mem_pkg.sv - shared types and widths for the SCARV RAM bus adapter
package scarv_mem_pkg;

  localparam int SCARV_MEM_DW        = 32;
  localparam int SCARV_MEM_SW        = 4;
  localparam int SCARV_MEM_BYTE_BITS = 2;

  // One buffered response as seen by the host.
  typedef struct packed {
    logic                    error;
    logic [SCARV_MEM_DW-1:0] rdata;
  } scarv_mem_rsp_t;

  // Request that was accepted last cycle and whose RAM data arrives this cycle.
  typedef struct packed {
    logic valid;
    logic wen;
    logic error;
  } scarv_mem_inflight_t;

  // Only good reads carry RAM data; writes and errors return zero.
  function automatic scarv_mem_rsp_t scarv_mem_make_rsp(
    input logic                    error,
    input logic                    wen,
    input logic [SCARV_MEM_DW-1:0] ram_rdata
  );
    scarv_mem_rsp_t rsp;
    rsp.error = error;
    rsp.rdata = (error || wen) ? '0 : ram_rdata;
    return rsp;
  endfunction

endpackage

// File: rtl/scarv_rsp_fifo.sv
// rtl/scarv_rsp_fifo.sv - small synchronous response FIFO with occupancy count
module scarv_rsp_fifo #(
  parameter int  DEPTH = 3,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           wdata,
  input  logic                       pop,
  output T                           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/scarv_ram_bus_adapter.sv
// rtl/scarv_ram_bus_adapter.sv - req/gnt host bus to single SRAM port bridge with buffered in-order responses
module scarv_ram_bus_adapter
  import scarv_mem_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int          RSP_DEPTH = 3,
  localparam int         AW        = $clog2(DEPTH) - 1
) (
  input  logic                    g_clk,
  input  logic                    g_reset,
  input  logic                    mem_req,
  output logic                    mem_gnt,
  input  logic                    mem_wen,
  input  logic [SCARV_MEM_SW-1:0] mem_strb,
  input  logic [SCARV_MEM_DW-1:0] mem_wdata,
  input  logic [31:0]             mem_addr,
  output logic                    mem_recv,
  input  logic                    mem_ack,
  output logic                    mem_error,
  output logic [SCARV_MEM_DW-1:0] mem_rdata,
  output logic                    ram_cen,
  output logic                    ram_wen,
  output logic [SCARV_MEM_SW-1:0] ram_strb,
  output logic [SCARV_MEM_DW-1:0] ram_wdata,
  output logic [AW:0]             ram_addr,
  input  logic [SCARV_MEM_DW-1:0] ram_rdata
);

  localparam int          CW        = $clog2(RSP_DEPTH + 1);
  localparam logic [32:0] LIMIT     = {1'b0, BASE} + 33'(DEPTH) * 33'd4;
  localparam int          WORD_MSB  = AW + SCARV_MEM_BYTE_BITS;

  scarv_mem_inflight_t inflight_q, inflight_d;
  scarv_mem_rsp_t      rsp_push_data;
  scarv_mem_rsp_t      rsp_head;
  logic                rsp_push;
  logic                rsp_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         occ_sum;
  logic                in_range;
  logic                aligned;
  logic                addr_ok;
  logic                accept;

  // Window check: BASE is DEPTH*4 aligned, so the word index is a plain subtract of the low bits.
  assign in_range = ({1'b0, mem_addr} >= {1'b0, BASE}) && ({1'b0, mem_addr} < LIMIT);
  assign aligned  = (mem_addr[SCARV_MEM_BYTE_BITS-1:0] == '0);
  assign addr_ok  = in_range && aligned;

  // Grant counts the slot already claimed by the inflight request so the FIFO can never overflow.
  assign occ_sum  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q.valid};
  assign mem_gnt  = !g_reset && (occ_sum < (CW+1)'(RSP_DEPTH));
  assign accept   = mem_req && mem_gnt;

  // Bad requests still take a pipeline slot but never touch the RAM.
  assign ram_cen   = accept && addr_ok;
  assign ram_wen   = mem_wen;
  assign ram_strb  = mem_strb;
  assign ram_wdata = mem_wdata;
  assign ram_addr  = mem_addr[WORD_MSB:SCARV_MEM_BYTE_BITS] - BASE[WORD_MSB:SCARV_MEM_BYTE_BITS];

  // Capture what the accepted request needs to form its response next cycle.
  always_comb begin
    inflight_d       = '0;
    inflight_d.valid = accept;
    inflight_d.wen   = mem_wen;
    inflight_d.error = !addr_ok;
  end

  // Inflight register; reset drops a request whose RAM data has not come back yet.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign rsp_push      = inflight_q.valid;
  assign rsp_push_data = scarv_mem_make_rsp(inflight_q.error, inflight_q.wen, ram_rdata);
  assign rsp_pop       = mem_recv && mem_ack;

  scarv_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (scarv_mem_rsp_t)
  ) u_rsp_fifo (
    .clk   (g_clk),
    .rst   (g_reset),
    .push  (rsp_push),
    .wdata (rsp_push_data),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Response outputs come straight from the FIFO head and are zero when nothing is buffered.
  assign mem_recv  = !fifo_empty;
  assign mem_error = mem_recv && rsp_head.error;
  assign mem_rdata = mem_recv ? rsp_head.rdata : '0;

  // The grant rule must make a push into a full FIFO impossible.
  always_ff @(posedge g_clk) begin
    if (!g_reset) begin
      assert (!(rsp_push && fifo_full));
    end
  end

endmodule

// File: tb/tb_scarv_ram_bus_adapter.sv
// tb/tb_scarv_ram_bus_adapter.sv - scoreboard bench for scarv_ram_bus_adapter
module tb_scarv_ram_bus_adapter;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        g_clk;
  logic        g_reset;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;
  logic        ram_cen;
  logic        ram_wen;
  logic [3:0]  ram_strb;
  logic [31:0] ram_wdata;
  logic [11:0] ram_addr;
  logic [31:0] ram_rdata;

  scarv_ram_bus_adapter #(
    .DEPTH     (DEPTH),
    .BASE      (BASE),
    .RSP_DEPTH (3)
  ) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_recv  (mem_recv),
    .mem_ack   (mem_ack),
    .mem_error (mem_error),
    .mem_rdata (mem_rdata),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_strb  (ram_strb),
    .ram_wdata (ram_wdata),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic        pop_err_log[$];
  logic [31:0] pop_data_log[$];
  logic [31:0] ram    [DEPTH];
  logic [31:0] shadow [DEPTH];
  logic        ram_init_req;
  logic        exact_lat;
  int          n_checks;
  int          n_fail;
  int          n_pops;
  int          cyc;

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    logic [1:0] lo;
    lo = a[1:0];
    return (longint'(a) >= longint'(BASE)) &&
           (longint'(a) < longint'(BASE) + 4 * DEPTH) && (lo == 2'b00);
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // SRAM model: one-cycle read, byte-strobed write.
  always @(posedge g_clk) begin
    if (ram_init_req) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else if (ram_cen) begin
      if (ram_wen) begin
        for (int b = 0; b < 4; b++)
          if (ram_strb[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram[ram_addr];
      end
    end
  end

  // Scoreboard monitor: predicts each accepted request, checks each consumed response.
  exp_t        mon_e;
  logic        mon_acc;
  logic        mon_ok;
  int          mon_idx;
  always @(negedge g_clk) begin
    if (ram_init_req) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    end
    if (!g_reset) begin
      mon_acc = mem_req && mem_gnt;
      mon_ok  = addr_ok(mem_addr);
      n_checks++;
      if (ram_cen !== (mon_acc && mon_ok)) begin
        n_fail++;
        $display("FAIL ram_cen addr=%h actual=%b required=%b", mem_addr, ram_cen, mon_acc && mon_ok);
      end
      if (mon_acc && mon_ok) begin
        mon_idx = word_idx(mem_addr);
        n_checks++;
        if (ram_addr !== 12'(mon_idx)) begin
          n_fail++;
          $display("FAIL ram_addr actual=%0d required=%0d", ram_addr, mon_idx);
        end
      end
      if (mem_recv && mem_ack) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp actual=recv required=no response");
        end else begin
          mon_e = sb_q.pop_front();
          if ({mem_error, mem_rdata} !== {mon_e.err, mon_e.data}) begin
            n_fail++;
            $display("FAIL rsp actual=err%b/%h required=err%b/%h", mem_error, mem_rdata, mon_e.err, mon_e.data);
          end
          if (exact_lat) begin
            n_checks++;
            if (cyc != mon_e.cyc + 2) begin
              n_fail++;
              $display("FAIL latency actual=%0d required=2", cyc - mon_e.cyc);
            end
          end
        end
        pop_err_log.push_back(mem_error);
        pop_data_log.push_back(mem_rdata);
        n_pops++;
      end
      if (mon_acc) begin
        mon_e.err  = !mon_ok;
        mon_e.data = 32'h0;
        mon_e.cyc  = cyc;
        if (mon_ok) begin
          mon_idx = word_idx(mem_addr);
          if (mem_wen) begin
            for (int b = 0; b < 4; b++)
              if (mem_strb[b]) shadow[mon_idx][8*b +: 8] = mem_wdata[8*b +: 8];
          end else begin
            mon_e.data = shadow[mon_idx];
          end
        end
        sb_q.push_back(mon_e);
      end
    end
  end

  task automatic drive(input logic wen, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata);
    int t;
    mem_req   = 1'b1;
    mem_wen   = wen;
    mem_addr  = addr;
    mem_strb  = strb;
    mem_wdata = wdata;
    t = 0;
    @(negedge g_clk);
    while (!mem_gnt && t < 20) begin
      t++;
      @(negedge g_clk);
    end
    if (!mem_gnt) begin
      n_checks++;
      n_fail++;
      $display("FAIL drive_timeout actual=gnt low required=gnt within 20 cycles");
      mem_req = 1'b0;
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_err_log.delete();
    pop_data_log.delete();
    n_pops = 0;
  endtask

  task automatic wait_drain();
    int t;
    mem_req = 1'b0;
    t = 0;
    @(negedge g_clk);
    while ((sb_q.size() != 0 || mem_recv) && t < 40) begin
      t++;
      @(negedge g_clk);
    end
    n_checks++;
    if (sb_q.size() != 0 || mem_recv) begin
      n_fail++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_reset();
    g_reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_gnt, mem_recv, mem_error, mem_rdata} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_outputs actual=gnt%b recv%b err%b %h required=all zero", mem_gnt, mem_recv, mem_error, mem_rdata);
    end
    repeat (3) @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    @(negedge g_clk);
    n_checks++;
    if (mem_gnt !== 1'b1 || mem_recv !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release actual=gnt%b recv%b required=gnt1 recv0", mem_gnt, mem_recv);
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_write_read();
    logic [31:0] w6;
    w6 = (init_word(6) & 32'hFF00_FF00) | (32'hCAFE_F00D & 32'h00FF_00FF);
    clear_logs();
    mem_ack   = 1'b1;
    exact_lat = 1'b1;
    drive(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    drive(1'b1, BASE + 32'h14, 4'h0, 32'h1234_5678);
    drive(1'b1, BASE + 32'h18, 4'h5, 32'hCAFE_F00D);
    drive(1'b0, BASE + 32'h10, 4'h0, 32'h0);
    drive(1'b0, BASE + 32'h14, 4'h0, 32'h0);
    drive(1'b0, BASE + 32'h18, 4'h0, 32'h0);
    wait_drain();
    exact_lat = 1'b0;
    n_checks++;
    if (n_pops != 6) begin
      n_fail++;
      $display("FAIL wr_rd_count actual=%0d required=6", n_pops);
    end else begin
      n_checks++;
      if (pop_data_log[0] !== 32'h0 || pop_err_log[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL write_rsp actual=%h/%b required=0/0", pop_data_log[0], pop_err_log[1]);
      end
      n_checks++;
      if (pop_data_log[3] !== 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL read_full actual=%h required=deadbeef", pop_data_log[3]);
      end
      n_checks++;
      if (pop_data_log[4] !== init_word(5)) begin
        n_fail++;
        $display("FAIL read_strb0 actual=%h required=%h", pop_data_log[4], init_word(5));
      end
      n_checks++;
      if (pop_data_log[5] !== w6) begin
        n_fail++;
        $display("FAIL read_partial actual=%h required=%h", pop_data_log[5], w6);
      end
    end
  endtask

  task automatic test_errors();
    clear_logs();
    mem_ack = 1'b1;
    drive(1'b0, BASE + 32'(4 * DEPTH), 4'h0, 32'h0);
    drive(1'b0, BASE + 32'h2, 4'h0, 32'h0);
    drive(1'b0, BASE - 32'h4, 4'h0, 32'h0);
    drive(1'b1, BASE + 32'(4 * DEPTH) + 32'h40, 4'hF, 32'hFFFF_FFFF);
    wait_drain();
    n_checks++;
    if (n_pops != 4) begin
      n_fail++;
      $display("FAIL err_count actual=%0d required=4", n_pops);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (pop_err_log[i] !== 1'b1 || pop_data_log[i] !== 32'h0) begin
          n_fail++;
          $display("FAIL err_rsp%0d actual=err%b/%h required=err1/0", i, pop_err_log[i], pop_data_log[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int start;
    clear_logs();
    mem_ack   = 1'b1;
    exact_lat = 1'b1;
    start     = cyc;
    for (int i = 0; i < 8; i++) drive(1'b0, BASE + 32'(4 * i), 4'h0, 32'h0);
    n_checks++;
    if (cyc - start != 8) begin
      n_fail++;
      $display("FAIL b2b_cycles actual=%0d required=8", cyc - start);
    end
    wait_drain();
    exact_lat = 1'b0;
    n_checks++;
    if (n_pops != 8) begin
      n_fail++;
      $display("FAIL b2b_count actual=%0d required=8", n_pops);
    end
  endtask

  task automatic test_backpressure();
    int n_acc;
    clear_logs();
    mem_ack  = 1'b0;
    mem_wen  = 1'b0;
    mem_strb = 4'h0;
    n_acc    = 0;
    mem_req  = 1'b1;
    mem_addr = BASE + 32'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge g_clk);
      if (mem_gnt) n_acc++;
      @(posedge g_clk);
      #1;
      mem_addr = BASE + 32'(4 * (8 + n_acc));
    end
    @(negedge g_clk);
    n_checks++;
    if (mem_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_gnt actual=%b required=0", mem_gnt);
    end
    n_checks++;
    if (n_acc != 3) begin
      n_fail++;
      $display("FAIL bp_accepts actual=%0d required=3", n_acc);
    end
    @(posedge g_clk);
    #1;
    mem_req = 1'b0;
    mem_ack = 1'b1;
    wait_drain();
    n_checks++;
    if (n_pops != 3) begin
      n_fail++;
      $display("FAIL bp_drain actual=%0d required=3", n_pops);
    end
  endtask

  task automatic test_order();
    clear_logs();
    mem_ack = 1'b1;
    drive(1'b0, BASE + 32'h40, 4'h0, 32'h0);
    drive(1'b0, BASE + 32'h41, 4'h0, 32'h0);
    drive(1'b0, BASE + 32'h44, 4'h0, 32'h0);
    wait_drain();
    n_checks++;
    if (n_pops != 3 || pop_err_log[0] !== 1'b0 || pop_err_log[1] !== 1'b1 || pop_err_log[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL order actual=%0d pops required=good,error,good", n_pops);
    end
  endtask

  task automatic test_reset_midop();
    clear_logs();
    mem_ack = 1'b0;
    drive(1'b0, BASE + 32'h50, 4'h0, 32'h0);
    drive(1'b0, BASE + 32'h54, 4'h0, 32'h0);
    drive(1'b0, BASE + 32'h58, 4'h0, 32'h0);
    mem_req = 1'b0;
    n_checks++;
    if (mem_recv !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_buffered actual=recv%b required=recv1", mem_recv);
    end
    g_reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_gnt, mem_recv, mem_error, mem_rdata} !== 35'h0) begin
      n_fail++;
      $display("FAIL midop_reset actual=gnt%b recv%b err%b %h required=all zero", mem_gnt, mem_recv, mem_error, mem_rdata);
    end
    sb_q.delete();
    repeat (2) @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge g_clk);
    n_checks++;
    if (mem_gnt !== 1'b1 || mem_recv !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_release actual=gnt%b recv%b required=gnt1 recv0", mem_gnt, mem_recv);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge g_clk);
      n_checks++;
      if (mem_recv !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_rsp actual=recv%b required=recv0", mem_recv);
      end
    end
    @(posedge g_clk);
    #1;
    clear_logs();
    drive(1'b0, BASE + 32'h10, 4'h0, 32'h0);
    wait_drain();
    n_checks++;
    if (n_pops != 1 || pop_data_log[0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL post_reset_read actual=%0d pops required=1 with deadbeef", n_pops);
    end
  endtask

  initial begin
    ram_init_req = 1'b1;
    exact_lat    = 1'b0;
    n_checks     = 0;
    n_fail       = 0;
    n_pops       = 0;
    cyc          = 0;
    mem_req      = 1'b0;
    mem_wen      = 1'b0;
    mem_strb     = 4'h0;
    mem_wdata    = 32'h0;
    mem_addr     = 32'h0;
    mem_ack      = 1'b0;
    ram_rdata    = 32'h0;
    g_reset      = 1'b1;
    fork
      begin
        repeat (2) @(negedge g_clk);
        ram_init_req = 1'b0;
      end
      test_reset();
    join
    test_write_read();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_order();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
